// File: rtl/dbl_frame_buffer.sv
`default_nettype none
// ============================================================================
// dbl_frame_buffer : double-buffered frame store. The renderer writes the back
// bank, scan-out reads the front bank, and banks swap at frame start.
// Optional clear engine: define FB_AUTO_CLEAR_EN.
// Revision: 1.0
// ============================================================================
module dbl_frame_buffer #(
  parameter int               H_RES       = 640,
  parameter int               V_RES       = 480,
  parameter int               PIX_W       = 8,
  parameter logic [PIX_W-1:0] TRANSPARENT = 8'h00,
  parameter logic [PIX_W-1:0] CLEAR_COLOR = 8'h00,
  parameter int               ADDR_W      = $clog2(H_RES*V_RES)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  input  logic             blank,
  input  logic             frame_start,
  input  logic             wr_en,
  input  logic [9:0]       wr_x,
  input  logic [9:0]       wr_y,
  input  logic [PIX_W-1:0] wr_data,
  output logic             wr_ready,
  input  logic             swap_req,
  output logic             swap_ready,
  output logic             swap_done,
  output logic             front_sel,
  output logic [PIX_W-1:0] pixel_out
);

  localparam int DEPTH = H_RES * V_RES;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PENDING = 2'd1;
`ifdef FB_AUTO_CLEAR_EN
  localparam logic [1:0] S_CLEAR   = 2'd2;
`endif

  logic [PIX_W-1:0] bank0 [DEPTH];
  logic [PIX_W-1:0] bank1 [DEPTH];

  logic [1:0]        state;
  logic              rd_in_range;
  logic              wr_in_range;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_data;

  // H_RES is a constant, so the row multiply reduces to shifts/adds
  assign rd_in_range = (32'(DrawX) < H_RES) && (32'(DrawY) < V_RES);
  assign wr_in_range = (32'(wr_x) < H_RES) && (32'(wr_y) < V_RES);
  assign rd_addr     = ADDR_W'(32'(DrawY) * H_RES + 32'(DrawX));
  assign wr_addr     = ADDR_W'(32'(wr_y) * H_RES + 32'(wr_x));

  assign swap_ready = (state == S_IDLE);

`ifdef FB_AUTO_CLEAR_EN
  logic [ADDR_W-1:0] clr_cnt;
  logic              clearing;

  assign clearing = (state == S_CLEAR);
  assign wr_ready = !clearing;
`else
  assign wr_ready = 1'b1;
`endif

  assign wr_accept = wr_en && wr_ready && (wr_data != TRANSPARENT) &&
                     wr_in_range && !Reset;

  // Single write port per bank, shared by the renderer and the clear engine
  always_comb begin
    mem_we   = wr_accept;
    mem_addr = wr_addr;
    mem_data = wr_data;
`ifdef FB_AUTO_CLEAR_EN
    if (clearing) begin
      mem_we   = !Reset;
      mem_addr = clr_cnt;
      mem_data = CLEAR_COLOR;
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (mem_we) begin
      if (front_sel) begin
        bank0[mem_addr] <= mem_data;
      end else begin
        bank1[mem_addr] <= mem_data;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pixel_out <= '0;
    end else if (!blank && rd_in_range) begin
      pixel_out <= front_sel ? bank1[rd_addr] : bank0[rd_addr];
    end else begin
      pixel_out <= '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= S_IDLE;
      front_sel <= 1'b0;
      swap_done <= 1'b0;
`ifdef FB_AUTO_CLEAR_EN
      clr_cnt   <= '0;
`endif
    end else begin
      swap_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (swap_req) begin
            state <= S_PENDING;
          end
        end
        S_PENDING: begin
          if (frame_start) begin
            front_sel <= !front_sel;
            swap_done <= 1'b1;
`ifdef FB_AUTO_CLEAR_EN
            state     <= S_CLEAR;
`else
            state     <= S_IDLE;
`endif
          end
        end
`ifdef FB_AUTO_CLEAR_EN
        S_CLEAR: begin
          if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
            clr_cnt <= '0;
            state   <= S_IDLE;
          end else begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dbl_frame_buffer.sv
`default_nettype none
// tb_dbl_frame_buffer : table vectors, corner sequences and randomized traffic
// checked against a bank-array reference model.
module tb_dbl_frame_buffer;

  localparam int H = 8;
  localparam int V = 4;
  localparam int N = H * V;
  localparam logic [7:0] CLR = 8'h11;
`ifdef FB_AUTO_CLEAR_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [9:0] DrawX = '0, DrawY = '0;
  logic       blank = 1'b1, frame_start = 1'b0, wr_en = 1'b0, swap_req = 1'b0;
  logic [9:0] wr_x = '0, wr_y = '0;
  logic [7:0] wr_data = '0;
  logic       wr_ready, swap_ready, swap_done, front_sel;
  logic [7:0] pixel_out;

  dbl_frame_buffer #(
    .H_RES(H), .V_RES(V), .PIX_W(8), .TRANSPARENT(8'h00), .CLEAR_COLOR(CLR)
  ) dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_start(frame_start), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
    .wr_data(wr_data), .wr_ready(wr_ready), .swap_req(swap_req),
    .swap_ready(swap_ready), .swap_done(swap_done), .front_sel(front_sel),
    .pixel_out(pixel_out)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  // Reference model: two banks as plain arrays, a pending flag, cycles of clear left
  int mm [2][N];
  bit known [2][N];
  bit m_front = 1'b0;
  bit m_pending = 1'b0;
  int m_clr = 0;
  int exp_pix = 0;
  bit pix_known = 1'b1;
  bit exp_done = 1'b0;

  typedef struct {
    bit blank; int dx; int dy;
    bit we; int wx; int wy; int wd;
    bit sreq; bit fs; bit waitclr;
    int exp_front; int exp_pix;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step();
    int ra, wa;
    bit rin, win;
    exp_done = 1'b0;
    if (Reset) begin
      exp_pix = 0; pix_known = 1'b1;
      m_front = 1'b0; m_pending = 1'b0; m_clr = 0;
    end else begin
      rin = !blank && int'(DrawX) < H && int'(DrawY) < V;
      ra  = int'(DrawY) * H + int'(DrawX);
      if (!rin) begin
        exp_pix = 0; pix_known = 1'b1;
      end else begin
        exp_pix = mm[m_front][ra]; pix_known = known[m_front][ra];
      end
      win = wr_en && m_clr == 0 && wr_data != 8'h00 && int'(wr_x) < H && int'(wr_y) < V;
      if (win) begin
        wa = int'(wr_y) * H + int'(wr_x);
        mm[!m_front][wa] = int'(wr_data);
        known[!m_front][wa] = 1'b1;
      end
      if (m_clr > 0) begin
        mm[!m_front][N - m_clr] = int'(CLR);
        known[!m_front][N - m_clr] = 1'b1;
        m_clr--;
      end else if (m_pending) begin
        if (frame_start) begin
          m_front = !m_front; exp_done = 1'b1; m_pending = 1'b0;
          m_clr = AUTO ? N : 0;
        end
      end else if (swap_req) begin
        m_pending = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge Clk);
    model_step();
    #1;
    if (pix_known) chk("pixel_out", 32'(pixel_out), 32'(exp_pix));
    chk("front_sel", 32'(front_sel), 32'(m_front));
    chk("swap_done", 32'(swap_done), 32'(exp_done));
    chk("swap_ready", 32'(swap_ready), 32'(!m_pending && m_clr == 0));
    chk("wr_ready", 32'(wr_ready), 32'(m_clr == 0));
  endtask

  task automatic idle_in();
    blank = 1'b1; DrawX = '0; DrawY = '0; wr_en = 1'b0; wr_x = '0; wr_y = '0;
    wr_data = '0; swap_req = 1'b0; frame_start = 1'b0; Reset = 1'b0;
  endtask

  task automatic wait_clear();
    int n = 0;
    while (!wr_ready && n < 100) begin
      cycle(); n++;
    end
    if (n >= 100) chk("wait_clear_timeout", 32'(n), 32'(0));
  endtask

  task automatic do_swap();
    swap_req = 1'b1; cycle(); swap_req = 1'b0;
    frame_start = 1'b1; cycle(); frame_start = 1'b0;
  endtask

  task automatic fill_back();
    for (int a = 0; a < N; a++) begin
      wr_en = 1'b1; wr_x = 10'(a % H); wr_y = 10'(a / H);
      wr_data = 8'($urandom_range(1, 255));
      cycle();
    end
    wr_en = 1'b0;
  endtask

  vec_t vecs [16];

  initial begin
    //          blank dx dy we wx wy wd     sreq fs wait front pix
    vecs[0]  = '{1, 0, 0, 1, 3, 2, 'h5A, 0, 0, 0, 0,  0};
    vecs[1]  = '{1, 0, 0, 0, 0, 0, 0,    1, 0, 0, 0,  0};
    vecs[2]  = '{1, 0, 0, 0, 0, 0, 0,    0, 1, 0, 1,  0};
    vecs[3]  = '{1, 0, 0, 0, 0, 0, 0,    0, 0, 1, -1, -1};
    vecs[4]  = '{0, 3, 2, 0, 0, 0, 0,    0, 0, 0, 1,  'h5A};
    vecs[5]  = '{1, 3, 2, 0, 0, 0, 0,    0, 0, 0, 1,  0};
    vecs[6]  = '{0, 3, 2, 1, 5, 1, 'h5A, 0, 0, 0, 1,  'h5A};
    vecs[7]  = '{1, 0, 0, 1, 5, 1, 'h00, 0, 0, 0, 1,  0};
    vecs[8]  = '{0, 8, 0, 1, 8, 0, 'h77, 0, 0, 0, 1,  0};
    vecs[9]  = '{0, 0, 4, 1, 0, 4, 'h77, 0, 0, 0, 1,  0};
    vecs[10] = '{1, 0, 0, 0, 0, 0, 0,    1, 1, 0, 1,  0};
    vecs[11] = '{1, 0, 0, 0, 0, 0, 0,    0, 1, 0, 0,  0};
    vecs[12] = '{1, 0, 0, 0, 0, 0, 0,    0, 0, 1, -1, -1};
    vecs[13] = '{0, 5, 1, 0, 0, 0, 0,    0, 0, 0, 0,  'h5A};
    vecs[14] = '{0, 0, 1, 0, 0, 0, 0,    0, 1, 0, 0,  -1};
    vecs[15] = '{0, 0, 1, 0, 0, 0, 0,    0, 0, 0, 0,  -1};

    // Reset with a visible in-range coordinate presented
    Reset = 1'b1; blank = 1'b0; DrawX = 10'd3; DrawY = 10'd2;
    repeat (3) cycle();
    chk("rst_pixel_out", 32'(pixel_out), 32'(0));
    chk("rst_front_sel", 32'(front_sel), 32'(0));
    chk("rst_swap_ready", 32'(swap_ready), 32'(1));
    idle_in();

    // Make both banks fully known
    fill_back(); do_swap(); wait_clear();
    fill_back(); do_swap(); wait_clear();

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].waitclr) begin
        wait_clear();
        continue;
      end
      blank = vecs[i].blank; DrawX = 10'(vecs[i].dx); DrawY = 10'(vecs[i].dy);
      wr_en = vecs[i].we; wr_x = 10'(vecs[i].wx); wr_y = 10'(vecs[i].wy);
      wr_data = 8'(vecs[i].wd); swap_req = vecs[i].sreq; frame_start = vecs[i].fs;
      cycle();
      if (vecs[i].exp_front >= 0) chk($sformatf("tbl%0d_front", i), 32'(front_sel), 32'(vecs[i].exp_front));
      if (vecs[i].exp_pix >= 0) chk($sformatf("tbl%0d_pixel", i), 32'(pixel_out), 32'(vecs[i].exp_pix));
      idle_in();
    end

`ifdef FB_AUTO_CLEAR_EN
    begin
      int n = 0;
      do_swap();
      while (!wr_ready && n < 100) begin
        wr_en = (n == 0); wr_x = 10'd2; wr_y = 10'd2; wr_data = 8'h33;
        cycle(); n++;
      end
      wr_en = 1'b0;
      chk("clear_cycles", 32'(n), 32'(N));
      do_swap(); wait_clear();
      for (int a = 0; a < N; a++) begin
        blank = 1'b0; DrawX = 10'(a % H); DrawY = 10'(a / H);
        cycle();
        chk($sformatf("cleared_px%0d", a), 32'(pixel_out), 32'(CLR));
      end
      idle_in();
      do_swap();
      repeat (10) cycle();
    end
`else
    swap_req = 1'b1; cycle(); swap_req = 1'b0;
`endif
    // Reset mid-operation
    Reset = 1'b1; cycle(); Reset = 1'b0;
    chk("midrst_swap_ready", 32'(swap_ready), 32'(1));
    chk("midrst_wr_ready", 32'(wr_ready), 32'(1));
    chk("midrst_front_sel", 32'(front_sel), 32'(0));

    for (int c = 0; c < 1500; c++) begin
      blank = ($urandom % 4) == 0;
      DrawX = 10'($urandom_range(0, 9)); DrawY = 10'($urandom_range(0, 5));
      wr_en = $urandom % 2; wr_x = 10'($urandom_range(0, 9)); wr_y = 10'($urandom_range(0, 5));
      wr_data = (($urandom % 4) == 0) ? 8'h00 : 8'($urandom);
      swap_req = ($urandom % 20) == 0; frame_start = ($urandom % 40) == 0;
      Reset = ($urandom % 300) == 0;
      cycle();
    end
    idle_in();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dbl_frame_buffer.md
# dbl_frame_buffer

Parametrised double-buffered frame store between the sprite/background renderer and the VGA scan-out. The renderer writes pixels into a back bank by (x, y) coordinate, skipping a transparent colour key. The VGA controller reads the front bank with one-cycle latency. A swap request exchanges the banks at the next frame start. An optional clear engine then fills the new back bank with a background colour.

## Interface
Parameters:
- H_RES, 640, visible pixels per line
- V_RES, 480, visible lines per frame
- PIX_W, 8, bits per pixel
- TRANSPARENT, 8'h00, colour key; writes of this value are dropped
- CLEAR_COLOR, 8'h00, fill value used by the clear engine
- ADDR_W, $clog2(H_RES*V_RES), bank address width (derived)

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- DrawX  in  10  scan-out column
- DrawY  in  10  scan-out row
- blank  in  1  high when scan-out is outside the visible area
- frame_start  in  1  one-cycle pulse at the start of each frame (vblank entry)
- wr_en  in  1  renderer pixel write strobe
- wr_x  in  10  write column
- wr_y  in  10  write row
- wr_data  in  PIX_W  write pixel
- wr_ready  out  1  high when writes are accepted (not clearing)
- swap_req  in  1  request a bank swap
- swap_ready  out  1  high when swap_req is accepted (state IDLE)
- swap_done  out  1  one-cycle pulse when the swap takes effect
- front_sel  out  1  bank currently scanned out
- pixel_out  out  PIX_W  front-bank pixel, registered

## Operation
- Storage: two banks of H_RES*V_RES words, inferred as synchronous RAM. Memory contents are not reset.
- Address is y*H_RES + x. H_RES is a constant, so no general multiplier is needed.
- Read path:
  - rd_addr is formed from DrawX/DrawY and reads the front bank.
  - pixel_out is forced to 0 if the registered blank is high or the registered coordinate is out of range (x ≥ H_RES or y ≥ V_RES).
- Write path:
  - Writes go to the back bank (!front_sel) when wr_en & wr_ready & wr_data≠TRANSPARENT & coordinate in range.
  - All other writes are dropped silently. No error flag.
- Swap FSM states: IDLE, PENDING, CLEAR.
  - IDLE: swap_ready=1. swap_req → PENDING.
  - PENDING: swap_ready=0. frame_start → toggle front_sel, pulse swap_done, → CLEAR (or → IDLE when clear is compiled out).
  - CLEAR: counter walks addresses 0..H_RES*V_RES-1, one word per cycle, writing CLEAR_COLOR to the new back bank. Renderer writes are blocked (wr_ready=0). Last address → IDLE.
- Simultaneous swap_req and frame_start in IDLE: the request is registered and the swap happens at the next frame_start, not the current one.
- frame_start in IDLE or CLEAR: no effect.
- Reset mid-operation: FSM returns to IDLE, the clear counter is abandoned, and bank contents are left partial.

## Timing
- Reset values: pixel_out=0, front_sel=0, swap_done=0, swap_ready=1, wr_ready=1, FSM=IDLE, clear counter=0.
- Read latency: 1 cycle. Coordinates sampled at edge N appear on pixel_out after edge N; blank is pipelined alongside them.
- Write: data committed at the edge where it is accepted. A read of the same address, same bank, same cycle returns old data.
- swap_done asserts during the cycle after the edge where frame_start was sampled in PENDING. front_sel changes on that same edge.
- Clear occupies exactly H_RES*V_RES cycles. wr_ready rises on the cycle after the last clear write.
- A read issued in the swap cycle uses the old front_sel; the following read uses the new one.

## Configuration
- FB_AUTO_CLEAR_EN defined:
  - The CLEAR state and counter exist.
  - After each swap the back bank is filled with CLEAR_COLOR and wr_ready drops for H_RES*V_RES cycles.
- FB_AUTO_CLEAR_EN undefined:
  - No clear logic. PENDING → IDLE directly and wr_ready is tied to 1.
  - The back bank keeps the contents of the frame before last.

## Test plan
Parameters for the bench: H_RES=8, V_RES=4, PIX_W=8.
- Reset, then read (3,2) with blank=0 → pixel_out=0, front_sel=0, swap_ready=1.
- Write 8'h5A to (3,2), swap_req, then frame_start → swap_done pulses once and front_sel=1. Read (3,2) → 8'h5A one cycle later. Read with blank=1 → 0.
- Write 8'h00 (TRANSPARENT) over a stored 8'h5A, and write to (8,0) and (0,4) → the 8'h5A pixel is unchanged and out-of-range reads return 0.
- With FB_AUTO_CLEAR_EN and CLEAR_COLOR=8'h11: swap → wr_ready low for exactly 32 cycles. A write during clear is dropped. After the next swap every address reads 8'h11.
- swap_req and frame_start in the same cycle → no swap. The next frame_start swaps. frame_start while IDLE → front_sel unchanged.
- Reset asserted mid-clear at count 10 → FSM=IDLE, wr_ready=1, front_sel=0 on the next cycle.
